in_ram_loader: RTL and testbench
================================

IN_RAM_LOADER -- requirements
Module: in_ram_loader

Interface
REQ-001 SHALL have parameter WIDTH, default 16, meaning operand word width.
REQ-002 SHALL have parameter DEPTH, default 16, meaning words per frame; AW = log2(DEPTH) = 4.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 s_valid  input  1  producer offers s_data this cycle.
REQ-006 s_data  input  WIDTH  operand word from producer.
REQ-007 s_ready  output  1  loader accepts a word this cycle.
REQ-008 rd_addr  input  AW  consumer read address.
REQ-009 rd_data  output  WIDTH  combinational mem[rd_addr].
REQ-010 start  output  1  one-cycle pulse: frame complete, consumer may begin.
REQ-011 full  output  1  frame held for consumer.
REQ-012 release  input  1  consumer pulse: frame consumed, buffer free.
REQ-013 clear  input  1  synchronous abort of current frame.
REQ-014 level  output  AW+1  words written in current frame, 0..DEPTH.

Function
REQ-015 SHALL hold a DEPTH x WIDTH register array, one write port (loader), one asynchronous read port (rd_addr/rd_data).
REQ-016 SHALL implement FSM states FILL, START, HOLD.
REQ-017 Accept = s_valid & s_ready; on accept SHALL write s_data to mem[wr_ptr] and increment wr_ptr and level by 1.
REQ-018 s_ready SHALL be 1 in FILL only, 0 in START and HOLD; independent of s_valid.
REQ-019 FILL -> START on the accept that writes address DEPTH-1; wr_ptr wraps to 0, level becomes DEPTH.
REQ-020 START SHALL assert start=1 for exactly one cycle, then unconditionally -> HOLD.
REQ-021 full SHALL be 1 in START and HOLD, 0 in FILL.
REQ-022 HOLD -> FILL when release=1; level cleared to 0, wr_ptr 0.
REQ-023 release in FILL or START SHALL be ignored.
REQ-024 clear=1 in any state SHALL force FILL, wr_ptr=0, level=0, no start pulse; memory contents retained.
REQ-025 clear coincident with s_valid: the beat SHALL NOT be written (clear wins).
REQ-026 clear coincident with release: clear behaviour applies (same result).
REQ-027 rd_data SHALL reflect a write to rd_addr from the cycle after the write edge (no write-through bypass).
REQ-028 s_data SHALL be ignored when no accept occurs; no write otherwise.
REQ-029 Latency: last accepted word at edge N -> start=1 during cycle N+1 -> full=1 from cycle N+1.

Reset
REQ-030 On rst=1, asynchronously: state FILL, wr_ptr=0, level=0, start=0, full=0, s_ready=1 after reset deasserts, all memory words 0.
REQ-031 Reset mid-frame or in HOLD SHALL discard the frame and zero memory; no start pulse follows.

Verification
REQ-032 Full frame: reset, stream 16 words 0x0101..0x1010 with s_valid held 1 -> s_ready high 16 cycles, start pulses once the cycle after word 16, full=1, level=16, rd_addr=5 -> 0x0606.
REQ-033 Backpressure: in HOLD hold s_valid=1 with 0xFFFF for 10 cycles -> s_ready=0, memory unchanged, level=16; pulse release -> FILL, level=0, next word lands at address 0.
REQ-034 Bursty producer: s_valid toggled 1,0,1,0 over 32 cycles -> exactly 16 writes, start after 16th accept, no skipped or duplicated addresses.
REQ-035 Clear mid-frame: after 7 words assert clear with s_valid=1 -> beat dropped, level=0, then 16 new words complete a frame with start pulse; address 0 holds the first post-clear word.
REQ-036 Early release: pulse release during FILL at level=3 and during START -> ignored, full remains 1 after start, HOLD reached.
REQ-037 Async reset in HOLD: assert rst between clock edges -> full=0, level=0, rd_data=0 for every rd_addr immediately, no start pulse.

Source files
------------

// File: rtl/in_ram_loader.sv
// Frame loader: fills a DEPTH x WIDTH register array from a valid/ready stream,
// then holds the frame for a consumer until released.
module in_ram_loader #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s_valid,
  input  logic [WIDTH-1:0] s_data,
  output logic             s_ready,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data,
  output logic             start,
  output logic             full,
  input  logic             frame_release,
  input  logic             clear,
  output logic [AW:0]      level
);

  localparam logic [1:0] FILL  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] HOLD  = 2'd2;

  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
  localparam logic [AW-1:0] PTR_ONE   = {{(AW-1){1'b0}}, 1'b1};
  localparam logic [AW:0]   LVL_ONE   = {{AW{1'b0}}, 1'b1};

  logic [1:0]       state_q, state_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW:0]      level_q, level_d;
  logic             s_ready_q, s_ready_d;
  logic             start_q, start_d;
  logic             full_q, full_d;
  logic             we_s;
  logic [WIDTH-1:0] mem_q [DEPTH];

  // Next-state logic; clear overrides every state and drops any coincident beat.
  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    level_d  = level_q;
    we_s     = 1'b0;
    if (clear) begin
      state_d  = FILL;
      wr_ptr_d = {AW{1'b0}};
      level_d  = {(AW+1){1'b0}};
    end else begin
      case (state_q)
        FILL: begin
          if (s_valid && s_ready_q) begin
            we_s     = 1'b1;
            wr_ptr_d = wr_ptr_q + PTR_ONE;
            level_d  = level_q + LVL_ONE;
            if (wr_ptr_q == LAST_ADDR) begin
              state_d = START;
            end else begin
              state_d = FILL;
            end
          end else begin
            state_d = FILL;
          end
        end
        START: begin
          state_d = HOLD;
        end
        HOLD: begin
          if (frame_release) begin
            state_d  = FILL;
            wr_ptr_d = {AW{1'b0}};
            level_d  = {(AW+1){1'b0}};
          end else begin
            state_d = HOLD;
          end
        end
        default: begin
          state_d  = FILL;
          wr_ptr_d = {AW{1'b0}};
          level_d  = {(AW+1){1'b0}};
        end
      endcase
    end
  end

  // Outputs are decoded from the next state so they leave flops directly.
  always_comb begin
    s_ready_d = (state_d == FILL);
    start_d   = (state_d == START);
    full_d    = (state_d == START) || (state_d == HOLD);
  end

  // Control state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= FILL;
      wr_ptr_q  <= {AW{1'b0}};
      level_q   <= {(AW+1){1'b0}};
      s_ready_q <= 1'b1;
      start_q   <= 1'b0;
      full_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      level_q   <= level_d;
      s_ready_q <= s_ready_d;
      start_q   <= start_d;
      full_q    <= full_d;
    end
  end

  // Frame storage; reset zeroes every word so a discarded frame never leaks.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= {WIDTH{1'b0}};
      end
    end else if (we_s) begin
      mem_q[wr_ptr_q] <= s_data;
    end
  end

  assign rd_data = mem_q[rd_addr];
  assign s_ready = s_ready_q;
  assign start   = start_q;
  assign full    = full_q;
  assign level   = level_q;

endmodule

// File: tb/tb_in_ram_loader.sv
// Self-checking bench for in_ram_loader: vector table, directed frame sequences
// and randomized traffic against a frame-level reference model.
module tb_in_ram_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        s_valid = 1'b0;
  logic [15:0] s_data = 16'h0000;
  logic        s_ready;
  logic [3:0]  rd_addr = 4'h0;
  logic [15:0] rd_data;
  logic        start;
  logic        full;
  logic        frame_release = 1'b0;
  logic        clear = 1'b0;
  logic [4:0]  level;

  int checks = 0;
  int errors = 0;

  in_ram_loader dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .rd_addr(rd_addr), .rd_data(rd_data), .start(start), .full(full),
    .frame_release(frame_release), .clear(clear), .level(level)
  );

  always #5 clk = ~clk;

  // Reference model: a frame is a list of words; level is its length.
  logic [15:0] mem_m [16];
  int          level_m;
  bit          full_m;
  bit          start_m;

  task automatic model_reset();
    for (int i = 0; i < 16; i++) mem_m[i] = 16'h0000;
    level_m = 0; full_m = 1'b0; start_m = 1'b0;
  endtask

  task automatic model_step(input logic v, input logic [15:0] d, input logic rel, input logic clr);
    if (clr) begin
      level_m = 0; full_m = 1'b0; start_m = 1'b0;
    end else if (!full_m) begin
      if (v) begin
        mem_m[level_m] = d;
        level_m = level_m + 1;
        if (level_m == 16) begin
          full_m = 1'b1; start_m = 1'b1;
        end
      end
    end else if (start_m) begin
      start_m = 1'b0;
    end else if (rel) begin
      full_m = 1'b0; level_m = 0;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic compare_model();
    chk("s_ready", {31'd0, s_ready}, {31'd0, !full_m});
    chk("start",   {31'd0, start},   {31'd0, start_m});
    chk("full",    {31'd0, full},    {31'd0, full_m});
    chk("level",   {27'd0, level},   level_m);
    chk("rd_data", {16'd0, rd_data}, {16'd0, mem_m[rd_addr]});
  endtask

  task automatic cycle(input logic v, input logic [15:0] d, input logic rel,
                       input logic clr, input logic [3:0] a);
    @(negedge clk);
    s_valid = v; s_data = d; frame_release = rel; clear = clr; rd_addr = a;
    @(posedge clk);
    model_step(v, d, rel, clr);
    #1;
    compare_model();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; s_valid = 1'b0; frame_release = 1'b0; clear = 1'b0;
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    #1;
    compare_model();
  endtask

  typedef struct {
    logic        v;
    logic [15:0] d;
    logic        rel;
    logic        clr;
    logic [3:0]  a;
    logic        e_ready;
    logic        e_start;
    logic        e_full;
    logic [4:0]  e_level;
    logic [15:0] e_rd;
  } vec_t;

  vec_t vecs [6];
  int   starts;

  initial begin
    vecs[0] = '{1'b1, 16'h0A01, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 5'd1, 16'h0A01};
    vecs[1] = '{1'b1, 16'h0A02, 1'b1, 1'b0, 4'd1, 1'b1, 1'b0, 1'b0, 5'd2, 16'h0A02};
    vecs[2] = '{1'b0, 16'hDEAD, 1'b0, 1'b0, 4'd2, 1'b1, 1'b0, 1'b0, 5'd2, 16'h0000};
    vecs[3] = '{1'b1, 16'h0A03, 1'b0, 1'b1, 4'd2, 1'b1, 1'b0, 1'b0, 5'd0, 16'h0000};
    vecs[4] = '{1'b1, 16'h0B01, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 5'd1, 16'h0B01};
    vecs[5] = '{1'b0, 16'h0000, 1'b1, 1'b1, 4'd1, 1'b1, 1'b0, 1'b0, 5'd0, 16'h0A02};

    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    compare_model();

    // Vector table: short fill, ignored release, idle beat, clear wins, retention.
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      s_valid = vecs[i].v; s_data = vecs[i].d; frame_release = vecs[i].rel;
      clear = vecs[i].clr; rd_addr = vecs[i].a;
      @(posedge clk);
      model_step(vecs[i].v, vecs[i].d, vecs[i].rel, vecs[i].clr);
      #1;
      chk($sformatf("vec%0d.s_ready", i), {31'd0, s_ready}, {31'd0, vecs[i].e_ready});
      chk($sformatf("vec%0d.start", i),   {31'd0, start},   {31'd0, vecs[i].e_start});
      chk($sformatf("vec%0d.full", i),    {31'd0, full},    {31'd0, vecs[i].e_full});
      chk($sformatf("vec%0d.level", i),   {27'd0, level},   {27'd0, vecs[i].e_level});
      chk($sformatf("vec%0d.rd_data", i), {16'd0, rd_data}, {16'd0, vecs[i].e_rd});
    end

    // Full frame 0x0101..0x1010 with valid held high.
    do_reset();
    for (int k = 1; k <= 16; k++) begin
      cycle(1'b1, 16'(k * 16'h0101), 1'b0, 1'b0, 4'(k - 1));
      if (k < 16) chk("frame.start_early", {31'd0, start}, 32'd0);
    end
    chk("frame.start_pulse", {31'd0, start}, 32'd1);
    chk("frame.full", {31'd0, full}, 32'd1);
    chk("frame.level", {27'd0, level}, 32'd16);
    cycle(1'b1, 16'hFFFF, 1'b1, 1'b0, 4'd5);
    chk("frame.rd5", {16'd0, rd_data}, 32'h0606);
    chk("frame.start_once", {31'd0, start}, 32'd0);

    // Backpressure in HOLD, then release and refill from address 0.
    for (int k = 0; k < 10; k++) cycle(1'b1, 16'hFFFF, 1'b0, 1'b0, 4'(k));
    chk("bp.level", {27'd0, level}, 32'd16);
    chk("bp.ready", {31'd0, s_ready}, 32'd0);
    chk("bp.addr0", {16'd0, rd_data}, {16'd0, mem_m[rd_addr]});
    cycle(1'b0, 16'h0000, 1'b1, 1'b0, 4'd0);
    chk("rel.level", {27'd0, level}, 32'd0);
    chk("rel.full", {31'd0, full}, 32'd0);
    cycle(1'b1, 16'h1234, 1'b0, 1'b0, 4'd0);
    chk("rel.addr0", {16'd0, rd_data}, 32'h1234);

    // Bursty producer: valid toggles over 32 cycles.
    do_reset();
    starts = 0;
    for (int i = 0; i < 32; i++) begin
      cycle((i % 2) == 0, 16'(16'h2000 + i / 2), 1'b0, 1'b0, 4'(i / 2));
      if (start) starts++;
    end
    chk("burst.starts", starts, 32'd1);
    for (int a = 0; a < 16; a++) begin
      rd_addr = 4'(a);
      #1;
      chk($sformatf("burst.addr%0d", a), {16'd0, rd_data}, 32'(16'h2000 + a));
    end

    // Clear mid-frame with a coincident beat, then a fresh complete frame.
    do_reset();
    for (int i = 0; i < 7; i++) cycle(1'b1, 16'(16'h3000 + i), 1'b0, 1'b0, 4'(i));
    cycle(1'b1, 16'hBEEF, 1'b0, 1'b1, 4'd7);
    chk("clr.level", {27'd0, level}, 32'd0);
    for (int i = 0; i < 16; i++) cycle(1'b1, 16'(16'h4000 + i), 1'b0, 1'b0, 4'd0);
    chk("clr.start", {31'd0, start}, 32'd1);
    chk("clr.addr0", {16'd0, rd_data}, 32'h4000);

    // Early release at level 3 and during START is ignored.
    do_reset();
    for (int i = 0; i < 3; i++) cycle(1'b1, 16'(16'h5000 + i), 1'b0, 1'b0, 4'd0);
    cycle(1'b0, 16'h0000, 1'b1, 1'b0, 4'd0);
    chk("early.level3", {27'd0, level}, 32'd3);
    for (int i = 3; i < 16; i++) cycle(1'b1, 16'(16'h5000 + i), 1'b0, 1'b0, 4'd0);
    cycle(1'b0, 16'h0000, 1'b1, 1'b0, 4'd0);
    chk("early.full_after_start", {31'd0, full}, 32'd1);
    cycle(1'b0, 16'h0000, 1'b0, 1'b0, 4'd15);
    chk("early.hold", {31'd0, full}, 32'd1);

    // Asynchronous reset between edges while in HOLD.
    @(posedge clk);
    #3;
    rst = 1'b1;
    model_reset();
    #1;
    chk("arst.full", {31'd0, full}, 32'd0);
    chk("arst.level", {27'd0, level}, 32'd0);
    chk("arst.start", {31'd0, start}, 32'd0);
    for (int a = 0; a < 16; a++) begin
      rd_addr = 4'(a);
      #0.1;
      chk($sformatf("arst.rd%0d", a), {16'd0, rd_data}, 32'd0);
    end
    @(negedge clk);
    rst = 1'b0;
    starts = 0;
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0, 16'h0000, 1'b0, 1'b0, 4'd0);
      if (start) starts++;
    end
    chk("arst.no_start", starts, 32'd0);
    chk("arst.ready", {31'd0, s_ready}, 32'd1);

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      cycle(1'($urandom_range(0, 3) != 0), 16'($urandom()),
            1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 39) == 0),
            4'($urandom_range(0, 15)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
